// File: rtl/led_chain_receiver.sv
// Daisy-chain LED receiver node: hunts a frame header, captures one
// pixel word, and forwards the header plus all later bits downstream.
// Ports:
//   reCLK, globalReset      recovered clock, async active-low reset
//   rx_data, rx_valid       upstream serial bit and strobe
//   hdr_ref                 header pattern, MSB first on the wire
//   tx_data, tx_valid       downstream serial bit and strobe
//   pixel_data              latched pixel, channel 0 in MSBs
//   pixel_update            pulse coincident with a pixel_data change
//   capture_abort           pulse when a frame ends mid-capture
//   frame_busy              high while not hunting for a header
module led_chain_receiver #(
   parameter int CH_COUNT     = 3,
   parameter int CH_WIDTH     = 12,
   parameter int HDR_WIDTH    = 16,
   parameter int GAP_CYCLES   = 8,
   parameter int LATCH_AT_END = 0
) (
   input  logic                         reCLK,
   input  logic                         globalReset,
   input  logic                         rx_data,
   input  logic                         rx_valid,
   input  logic [HDR_WIDTH-1:0]         hdr_ref,
   output logic                         tx_data,
   output logic                         tx_valid,
   output logic [CH_COUNT*CH_WIDTH-1:0] pixel_data,
   output logic                         pixel_update,
   output logic                         capture_abort,
   output logic                         frame_busy
);

   localparam int PIX_W = CH_COUNT * CH_WIDTH;
   localparam int CNT_W = $clog2(PIX_W);
   localparam int GAP_W = $clog2(GAP_CYCLES);
   localparam int FL_W  = $clog2(HDR_WIDTH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(HDR_WIDTH - 1);

   typedef enum logic [1:0] {
      S_HUNT,
      S_CAPTURE,
      S_PASS,
      S_FLUSH
   } state_t;

   state_t r_state;
   state_t w_nstate;

   logic [HDR_WIDTH-1:0] r_win;
   logic [HDR_WIDTH-1:0] r_wval;
   logic [PIX_W-1:0]     r_cap;
   logic [CNT_W-1:0]     r_bitcnt;
   logic [GAP_W-1:0]     r_gap;
   logic [FL_W-1:0]      r_flcnt;
   logic                 r_tx_data;
   logic                 r_tx_valid;
   logic [PIX_W-1:0]     r_pix;
   logic                 r_upd;
   logic                 r_abort;
   logic                 r_busy;

   logic             w_match;
   logic             w_timeout;
   logic             w_cap_last;
   logic [PIX_W-1:0] w_cap_next;
   logic [PIX_W-1:0] w_load_val;
   logic             w_gap_run;
   logic             w_shift;
   logic             w_cap;
   logic             w_load;
   logic             w_abort;

   assign w_match    = (r_win == hdr_ref) && (&r_wval);
   assign w_gap_run  = (r_state == S_CAPTURE) || (r_state == S_PASS);
   assign w_timeout  = w_gap_run && !rx_valid && (r_gap == GAP_LAST);
   assign w_cap_last = (r_bitcnt == CNT_LAST);
   assign w_cap_next = {r_cap[PIX_W-2:0], rx_data};
   // Deferred latch takes the finished capture; immediate latch
   // includes the final bit arriving this cycle.
   assign w_load_val = (LATCH_AT_END != 0) ? r_cap : w_cap_next;

   always_ff @(posedge reCLK or negedge globalReset) begin
      if (!globalReset) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_nstate;
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_shift  = 1'b0;
      w_cap    = 1'b0;
      w_load   = 1'b0;
      w_abort  = 1'b0;
      unique case (r_state)
         S_HUNT: begin
            if (w_match) begin
               // Window freezes; a bit arriving now is pixel bit 0.
               w_nstate = S_CAPTURE;
               w_cap    = rx_valid;
               if (rx_valid && w_cap_last) begin
                  w_nstate = S_PASS;
                  w_load   = (LATCH_AT_END == 0);
               end
            end else begin
               w_shift = rx_valid;
            end
         end
         S_CAPTURE: begin
            if (w_timeout) begin
               w_nstate = S_FLUSH;
               w_abort  = 1'b1;
            end else if (rx_valid) begin
               w_cap = 1'b1;
               if (w_cap_last) begin
                  w_nstate = S_PASS;
                  w_load   = (LATCH_AT_END == 0);
               end
            end
         end
         S_PASS: begin
            if (w_timeout) begin
               w_nstate = S_FLUSH;
               w_load   = (LATCH_AT_END != 0);
            end else begin
               w_shift = rx_valid;
            end
         end
         S_FLUSH: begin
            // Drain every slot; bits of a new frame keep their valid.
            w_shift = 1'b1;
            if (r_flcnt == FL_LAST) begin
               w_nstate = S_HUNT;
            end
         end
         default: begin
            w_nstate = S_HUNT;
         end
      endcase
   end

   always_ff @(posedge reCLK or negedge globalReset) begin
      if (!globalReset) begin
         r_win      <= '0;
         r_wval     <= '0;
         r_cap      <= '0;
         r_bitcnt   <= '0;
         r_gap      <= '0;
         r_flcnt    <= '0;
         r_tx_data  <= 1'b0;
         r_tx_valid <= 1'b0;
         r_pix      <= '0;
         r_upd      <= 1'b0;
         r_abort    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_tx_valid <= w_shift & r_wval[HDR_WIDTH-1];
         r_tx_data  <= w_shift & r_win[HDR_WIDTH-1];
         if (w_shift) begin
            r_win  <= {r_win[HDR_WIDTH-2:0], rx_data};
            r_wval <= {r_wval[HDR_WIDTH-2:0], rx_valid};
         end
         if (w_abort) begin
            r_cap    <= '0;
            r_bitcnt <= '0;
         end else if (w_cap) begin
            r_cap    <= w_cap_next;
            r_bitcnt <= w_cap_last ? '0 : r_bitcnt + CNT_W'(1);
         end
         r_upd <= w_load;
         if (w_load) begin
            r_pix <= w_load_val;
         end
         r_abort <= w_abort;
         // Idle run length; restarts on any bit and on state change.
         if (!w_gap_run || rx_valid || (w_nstate != r_state)) begin
            r_gap <= '0;
         end else if (r_gap != GAP_LAST) begin
            r_gap <= r_gap + GAP_W'(1);
         end
         if (r_state == S_FLUSH && r_flcnt != FL_LAST) begin
            r_flcnt <= r_flcnt + FL_W'(1);
         end else begin
            r_flcnt <= '0;
         end
         r_busy <= (w_nstate != S_HUNT);
      end
   end

   assign tx_data       = r_tx_data;
   assign tx_valid      = r_tx_valid;
   assign pixel_data    = r_pix;
   assign pixel_update  = r_upd;
   assign capture_abort = r_abort;
   assign frame_busy    = r_busy;

endmodule

// File: tb/tb_led_chain_receiver.sv
// Directed bench for led_chain_receiver: immediate and deferred latch
// variants share one stimulus stream and are checked side by side.
module tb_led_chain_receiver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_data;
   logic        rx_valid;
   logic [15:0] hdr_ref;

   logic        tx_d0, tx_v0, upd0, ab0, busy0;
   logic        tx_d1, tx_v1, upd1, ab1, busy1;
   logic [35:0] pix0, pix1;

   int checks = 0;
   int errors = 0;
   int nupd0 = 0, nupd1 = 0, nab0 = 0, nab1 = 0;
   logic q0[$];
   logic q1[$];
   int gk = 0;
   bit bursty = 0;

   localparam logic [35:0] PIX  = 36'hABC123456;
   localparam logic [35:0] PIX2 = 36'h123456789;

   always #5 clk = ~clk;

   led_chain_receiver #(.LATCH_AT_END(0)) u_dut0 (
      .reCLK(clk), .globalReset(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .hdr_ref(hdr_ref),
      .tx_data(tx_d0), .tx_valid(tx_v0), .pixel_data(pix0),
      .pixel_update(upd0), .capture_abort(ab0), .frame_busy(busy0)
   );

   led_chain_receiver #(.LATCH_AT_END(1)) u_dut1 (
      .reCLK(clk), .globalReset(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .hdr_ref(hdr_ref),
      .tx_data(tx_d1), .tx_valid(tx_v1), .pixel_data(pix1),
      .pixel_update(upd1), .capture_abort(ab1), .frame_busy(busy1)
   );

   always @(negedge clk) begin
      if (tx_v0) q0.push_back(tx_d0);
      if (tx_v1) q1.push_back(tx_d1);
      if (upd0) nupd0++;
      if (upd1) nupd1++;
      if (ab0) nab0++;
      if (ab1) nab1++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [63:0] w, input int n, input bit first);
      for (int i = n - 1; i >= 0; i--) begin
         if (bursty && !(first && i == n - 1)) begin
            rx_valid = 1'b0;
            cyc(1 + gk % 7);
            gk++;
         end
         rx_data  = w[i];
         rx_valid = 1'b1;
         cyc(1);
      end
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      rx_data  = 1'b0;
      cyc(n);
   endtask

   task automatic popq(input bit sel, input int n, output logic [63:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         if (sel == 1'b0 && q0.size() > 0) v = {v[62:0], q0.pop_front()};
         if (sel == 1'b1 && q1.size() > 0) v = {v[62:0], q1.pop_front()};
      end
   endtask

   task automatic tail(input string tag, input logic [35:0] exp_pix1,
                       input logic exp_upd1, input logic exp_ab);
      idle(8);
      chk({tag, "_to_busy"}, busy0, 1);
      chk({tag, "_to_abort0"}, ab0, exp_ab);
      chk({tag, "_to_abort1"}, ab1, exp_ab);
      chk({tag, "_to_upd0"}, upd0, 0);
      chk({tag, "_to_upd1"}, upd1, exp_upd1);
      chk({tag, "_to_pix1"}, pix1, exp_pix1);
      cyc(15);
      chk({tag, "_flush_busy"}, busy0, 1);
      cyc(1);
      chk({tag, "_hunt0"}, busy0, 0);
      chk({tag, "_hunt1"}, busy1, 0);
      cyc(2);
   endtask

   task automatic basic_frame(input string tag, input logic [35:0] prev1);
      int s, b0, b1;
      logic [63:0] v;
      q0.delete();
      q1.delete();
      b0 = nupd0;
      b1 = nupd1;
      send(64'hFFFE, 16, 1);
      chk({tag, "_hdr_hunt"}, busy0, 0);
      s = q0.size();
      send(PIX, 36, 0);
      chk({tag, "_cap_quiet"}, q0.size() - s, 0);
      chk({tag, "_upd0_now"}, upd0, 1);
      chk({tag, "_pix0"}, pix0, PIX);
      chk({tag, "_upd1_now"}, upd1, 0);
      chk({tag, "_pix1_hold"}, pix1, prev1);
      send(64'h5A5A, 16, 0);
      tail(tag, PIX, 1, 0);
      chk({tag, "_txlen0"}, q0.size(), 32);
      chk({tag, "_txlen1"}, q1.size(), 32);
      popq(0, 32, v);
      chk({tag, "_tx0"}, v, 64'hFFFE5A5A);
      popq(1, 32, v);
      chk({tag, "_tx1"}, v, 64'hFFFE5A5A);
      chk({tag, "_nupd0"}, nupd0 - b0, 1);
      chk({tag, "_nupd1"}, nupd1 - b1, 1);
   endtask

   initial begin
      logic [63:0] v;
      int b0, b1, a0;
      rst_n    = 1'b0;
      rx_data  = 1'b0;
      rx_valid = 1'b0;
      hdr_ref  = 16'hFFFE;
      cyc(3);
      chk("rst_txv", tx_v0, 0);
      chk("rst_pix", pix0, 0);
      chk("rst_upd", upd0, 0);
      chk("rst_abort", ab0, 0);
      chk("rst_busy", busy0, 0);
      rst_n = 1'b1;
      cyc(2);
      chk("post_rst_busy", busy0, 0);

      basic_frame("basic", 36'h0);

      q0.delete();
      b0 = nupd0;
      b1 = nupd1;
      send(64'hFFFE, 16, 1);
      send(PIX2, 36, 0);
      chk("emb_pix0", pix0, PIX2);
      send(64'hFFFE, 16, 0);
      send(64'h5A5A, 16, 0);
      tail("emb", PIX2, 1, 0);
      chk("emb_txlen", q0.size(), 48);
      popq(0, 48, v);
      chk("emb_tx", v, 64'hFFFEFFFE5A5A);
      chk("emb_nupd0", nupd0 - b0, 1);
      chk("emb_nupd1", nupd1 - b1, 1);

      q0.delete();
      b0 = nupd0;
      a0 = nab0;
      send(64'hFFFE, 16, 1);
      send(64'hABCDE, 20, 0);
      tail("abort", PIX2, 0, 1);
      chk("abort_pix0", pix0, PIX2);
      chk("abort_pix1", pix1, PIX2);
      chk("abort_nab", nab0 - a0, 1);
      chk("abort_nupd", nupd0 - b0, 0);
      chk("abort_txlen", q0.size(), 16);
      popq(0, 16, v);
      chk("abort_tx", v, 64'hFFFE);

      bursty = 1;
      basic_frame("burst", PIX2);
      bursty = 0;

      send(64'hFFFE, 16, 1);
      send(PIX, 36, 0);
      send(64'h5A, 8, 0);
      chk("mid_txv", tx_v0, 1);
      chk("mid_busy", busy0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_txv", tx_v0, 0);
      chk("arst_txd", tx_d0, 0);
      chk("arst_pix", pix0, 0);
      chk("arst_upd", upd0, 0);
      chk("arst_abort", ab0, 0);
      chk("arst_busy", busy0, 0);
      q0.delete();
      idle(2);
      rst_n = 1'b1;
      idle(20);
      chk("arst_no_fwd", q0.size(), 0);
      chk("arst_hunt", busy0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
